// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: shared states, opcodes, operand selects, alu codes and decode record
package control_sequencer_pkg;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  localparam logic [6:0] OP_MOV_AB  = 7'h00;
  localparam logic [6:0] OP_MOV_BA  = 7'h01;
  localparam logic [6:0] OP_MOV_AL  = 7'h02;
  localparam logic [6:0] OP_MOV_BL  = 7'h03;
  localparam logic [6:0] OP_ADD_AB  = 7'h04;
  localparam logic [6:0] OP_ADD_BA  = 7'h05;
  localparam logic [6:0] OP_ADD_AL  = 7'h06;
  localparam logic [6:0] OP_SUB_AB  = 7'h07;
  localparam logic [6:0] OP_SHL_A   = 7'h08;
  localparam logic [6:0] OP_SHL_B   = 7'h09;
  localparam logic [6:0] OP_JMP     = 7'h0A;
  localparam logic [6:0] OP_NOP     = 7'h7E;
  localparam logic [6:0] OP_HALT    = 7'h7F;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SHL = 3'b110;

  localparam logic [1:0] SA_ZERO = 2'd0;
  localparam logic [1:0] SA_REGA = 2'd1;
  localparam logic [1:0] SA_REGB = 2'd2;
  localparam logic [1:0] SB_ZERO = 2'd0;
  localparam logic [1:0] SB_REGB = 2'd1;
  localparam logic [1:0] SB_LIT  = 2'd2;

  typedef struct packed {
    logic       load_a;
    logic       load_b;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic [2:0] alu_op;
    logic       jmp;
    logic       halt;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t mk(input logic la, input logic lb, input logic [1:0] sa,
                               input logic [1:0] sb, input logic [2:0] op);
    mk = '0;
    mk.load_a = la;
    mk.load_b = lb;
    mk.sel_a  = sa;
    mk.sel_b  = sb;
    mk.alu_op = op;
  endfunction
endpackage

// File: rtl/control_sequencer_decoder.sv
// cs_decoder: maps the instruction opcode to register loads, operand selects and alu op
module cs_decoder
  import control_sequencer_pkg::*;
(
  input  logic       en,
  input  logic [6:0] opcode,
  output ctrl_t      ctrl
);
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_MOV_AB: ctrl = mk(1'b1, 1'b0, SA_ZERO, SB_REGB, ALU_ADD);
      OP_MOV_BA: ctrl = mk(1'b0, 1'b1, SA_REGA, SB_ZERO, ALU_ADD);
      OP_MOV_AL: ctrl = mk(1'b1, 1'b0, SA_ZERO, SB_LIT,  ALU_ADD);
      OP_MOV_BL: ctrl = mk(1'b0, 1'b1, SA_ZERO, SB_LIT,  ALU_ADD);
      OP_ADD_AB: ctrl = mk(1'b1, 1'b0, SA_REGA, SB_REGB, ALU_ADD);
      OP_ADD_BA: ctrl = mk(1'b0, 1'b1, SA_REGA, SB_REGB, ALU_ADD);
      OP_ADD_AL: ctrl = mk(1'b1, 1'b0, SA_REGA, SB_LIT,  ALU_ADD);
      OP_SUB_AB: ctrl = mk(1'b1, 1'b0, SA_REGA, SB_REGB, ALU_SUB);
      OP_SHL_A:  ctrl = mk(1'b1, 1'b0, SA_REGA, SB_ZERO, ALU_SHL);
      OP_SHL_B:  ctrl = mk(1'b0, 1'b1, SA_REGB, SB_ZERO, ALU_SHL);
      OP_JMP:    ctrl.jmp = 1'b1;
      OP_NOP:    ctrl.jmp = 1'b0;
      OP_HALT:   ctrl.halt = 1'b1;
      default:   ctrl.illegal = 1'b1;
    endcase
    ctrl = en ? ctrl : '0;
  end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/execute fsm driving a two-register datapath from instruction memory
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int IW   = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic            im_req,
  output logic [PC_W-1:0] im_addr,
  input  logic            im_ack,
  input  logic [IW-1:0]   im_data,
  output logic            load_a,
  output logic            load_b,
  output logic [1:0]      sel_a,
  output logic [1:0]      sel_b,
  output logic [2:0]      alu_op,
  output logic [7:0]      literal,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            illegal
);
  logic [1:0]    state;
  logic [IW-1:0] ir;
  ctrl_t         ctrl;

  cs_decoder u_dec (
    .en     (state == S_EXEC),
    .opcode (ir[IW-1 -: 7]),
    .ctrl   (ctrl)
  );

  assign im_req  = state == S_FETCH;
  assign im_addr = pc;
  assign halted  = state == S_HALTED;
  assign literal = ir[7:0];
  assign load_a  = ctrl.load_a;
  assign load_b  = ctrl.load_b;
  assign sel_a   = ctrl.sel_a;
  assign sel_b   = ctrl.sel_b;
  assign alu_op  = ctrl.alu_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      pc      <= '0;
      ir      <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= run ? S_FETCH : S_IDLE;
        S_FETCH: if (im_ack) begin
          ir    <= im_data;
          pc    <= pc + 1'b1;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (ctrl.jmp) pc <= PC_W'(ir[7:0]);
          illegal <= illegal | ctrl.illegal;
          state   <= ctrl.halt ? S_HALTED : run ? S_FETCH : S_IDLE;
        end
        default: state <= S_HALTED;
      endcase
    end
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: decode table plus directed fetch/jump/halt/reset sequences with a datapath model
module tb_control_sequencer;
  logic        clk = 1'b0;
  logic        reset, run, im_ack, im_req;
  logic [14:0] im_data;
  logic [7:0]  im_addr, pc, literal;
  logic        load_a, load_b, halted, illegal;
  logic [1:0]  sel_a, sel_b;
  logic [2:0]  alu_op;

  control_sequencer #(.PC_W(8), .IW(15)) dut (
    .clk(clk), .reset(reset), .run(run), .im_req(im_req), .im_addr(im_addr),
    .im_ack(im_ack), .im_data(im_data), .load_a(load_a), .load_b(load_b),
    .sel_a(sel_a), .sel_b(sel_b), .alu_op(alu_op), .literal(literal),
    .pc(pc), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] instr;
    logic        la;
    logic        lb;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic [2:0]  op;
    logic        ill;
    logic [7:0]  npc;
  } vec_t;

  vec_t        vecs[13];
  logic [14:0] mem[256];
  int          checks = 0;
  int          errors = 0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  logic        ack_force = 1'b0;
  logic [7:0]  ra = 8'd0;
  logic [7:0]  rb = 8'd0;

  function automatic vec_t mkv(input logic [6:0] opc, input logic [7:0] lit, input logic la,
                               input logic lb, input logic [1:0] sa, input logic [1:0] sb,
                               input logic [2:0] op, input logic ill, input logic [7:0] npc);
    mkv.instr = {opc, lit};
    mkv.la = la;
    mkv.lb = lb;
    mkv.sa = sa;
    mkv.sb = sb;
    mkv.op = op;
    mkv.ill = ill;
    mkv.npc = npc;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    logic [7:0] opa, opb, res;
    if (ack_force || (im_req && wait_cnt >= ack_delay)) begin
      im_ack = 1'b1;
      im_data = mem[im_addr];
      wait_cnt = 0;
    end else begin
      im_ack = 1'b0;
      wait_cnt = im_req ? wait_cnt + 1 : 0;
    end
    if (load_a || load_b) begin
      opa = sel_a == 2'd1 ? ra : sel_a == 2'd2 ? rb : 8'd0;
      opb = sel_b == 2'd1 ? rb : sel_b == 2'd2 ? literal : 8'd0;
      res = alu_op == 3'b001 ? opa - opb : alu_op == 3'b110 ? opa << 1 : opa + opb;
      if (load_a) ra = res;
      if (load_b) rb = res;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run = 1'b0;
    ack_force = 1'b0;
    ack_delay = 0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    run = 1'b0;
    im_ack = 1'b0;
    im_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = {7'h7E, 8'h00};
    vecs[0]  = mkv(7'h00, 8'h11, 1'b1, 1'b0, 2'd0, 2'd1, 3'b000, 1'b0, 8'd1);
    vecs[1]  = mkv(7'h01, 8'h22, 1'b0, 1'b1, 2'd1, 2'd0, 3'b000, 1'b0, 8'd1);
    vecs[2]  = mkv(7'h02, 8'h33, 1'b1, 1'b0, 2'd0, 2'd2, 3'b000, 1'b0, 8'd1);
    vecs[3]  = mkv(7'h03, 8'h44, 1'b0, 1'b1, 2'd0, 2'd2, 3'b000, 1'b0, 8'd1);
    vecs[4]  = mkv(7'h04, 8'h55, 1'b1, 1'b0, 2'd1, 2'd1, 3'b000, 1'b0, 8'd1);
    vecs[5]  = mkv(7'h05, 8'h66, 1'b0, 1'b1, 2'd1, 2'd1, 3'b000, 1'b0, 8'd1);
    vecs[6]  = mkv(7'h06, 8'h77, 1'b1, 1'b0, 2'd1, 2'd2, 3'b000, 1'b0, 8'd1);
    vecs[7]  = mkv(7'h07, 8'h88, 1'b1, 1'b0, 2'd1, 2'd1, 3'b001, 1'b0, 8'd1);
    vecs[8]  = mkv(7'h08, 8'h99, 1'b1, 1'b0, 2'd1, 2'd0, 3'b110, 1'b0, 8'd1);
    vecs[9]  = mkv(7'h09, 8'hAA, 1'b0, 1'b1, 2'd2, 2'd0, 3'b110, 1'b0, 8'd1);
    vecs[10] = mkv(7'h0A, 8'h05, 1'b0, 1'b0, 2'd0, 2'd0, 3'b000, 1'b0, 8'd5);
    vecs[11] = mkv(7'h7E, 8'hBB, 1'b0, 1'b0, 2'd0, 2'd0, 3'b000, 1'b0, 8'd1);
    vecs[12] = mkv(7'h50, 8'hCC, 1'b0, 1'b0, 2'd0, 2'd0, 3'b000, 1'b1, 8'd1);

    do_reset();
    chk("reset_pc", pc, 0);
    chk("reset_req", im_req, 0);
    chk("reset_halted", halted, 0);
    chk("reset_illegal", illegal, 0);
    chk("reset_loads", {load_a, load_b, sel_a, sel_b, alu_op}, 0);

    for (int i = 0; i < 13; i++) begin
      do_reset();
      mem[0] = vecs[i].instr;
      run = 1'b1;
      step();
      chk("vec_fetch_req", im_req, 1);
      step();
      chk("vec_load_a", load_a, vecs[i].la);
      chk("vec_load_b", load_b, vecs[i].lb);
      chk("vec_sel_a", sel_a, vecs[i].sa);
      chk("vec_sel_b", sel_b, vecs[i].sb);
      chk("vec_alu_op", alu_op, vecs[i].op);
      chk("vec_literal", literal, vecs[i].instr[7:0]);
      chk("vec_exec_req", im_req, 0);
      step();
      chk("vec_illegal", illegal, vecs[i].ill);
      chk("vec_pc", pc, vecs[i].npc);
    end

    do_reset();
    mem[0] = {7'h02, 8'd42};
    mem[1] = {7'h03, 8'd123};
    run = 1'b1;
    step();
    chk("prog_c1_req", im_req, 1);
    step();
    chk("prog_c2_ctrl", {load_a, load_b, sel_b}, {1'b1, 1'b0, 2'd2});
    chk("prog_c2_lit", literal, 42);
    step();
    step();
    chk("prog_c4_ctrl", {load_a, load_b, sel_b}, {1'b0, 1'b1, 2'd2});
    chk("prog_c4_lit", literal, 123);
    chk("prog_c4_pc", pc, 2);
    step();
    chk("prog_ra", ra, 42);
    chk("prog_rb", rb, 123);

    do_reset();
    mem[0] = {7'h02, 8'd2};
    mem[1] = {7'h03, 8'd3};
    mem[2] = {7'h04, 8'd0};
    mem[3] = {7'h08, 8'd0};
    run = 1'b1;
    repeat (7) step();
    chk("dp_add", ra, 5);
    step();
    chk("dp_shl_op", {sel_a, alu_op}, {2'd1, 3'b110});
    step();
    chk("dp_shl", ra, 10);

    do_reset();
    mem[0] = {7'h7E, 8'h00};
    ack_delay = 3;
    run = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("wait_req", im_req, 1);
      chk("wait_addr", im_addr, 0);
      chk("wait_pc", pc, 0);
      step();
    end
    chk("wait_exec_req", im_req, 0);
    chk("wait_exec_pc", pc, 1);
    run = 1'b0;
    step();
    chk("wait_idle_req", im_req, 0);
    chk("wait_idle_pc", pc, 1);

    do_reset();
    mem[0] = {7'h02, 8'h09};
    ack_delay = 2;
    run = 1'b1;
    step();
    run = 1'b0;
    step();
    step();
    step();
    chk("drop_exec_load", load_a, 1);
    step();
    chk("drop_idle_req", im_req, 0);
    step();
    chk("drop_stay_idle", im_req, 0);

    do_reset();
    mem[0] = {7'h0A, 8'hFF};
    mem[255] = {7'h0A, 8'h05};
    run = 1'b1;
    repeat (3) step();
    chk("jmp_addr_ff", im_addr, 8'hFF);
    step();
    chk("jmp_wrap_pc", pc, 0);
    step();
    chk("jmp_addr_05", im_addr, 8'h05);
    do_reset();
    mem[255] = {7'h7E, 8'h00};
    run = 1'b1;
    repeat (5) step();
    chk("seq_wrap_addr", im_addr, 0);
    chk("seq_wrap_req", im_req, 1);

    do_reset();
    mem[0] = {7'h50, 8'h00};
    mem[1] = {7'h7E, 8'h00};
    mem[2] = {7'h7F, 8'h00};
    run = 1'b1;
    step();
    step();
    chk("ill_no_load", {load_a, load_b}, 0);
    step();
    chk("ill_set", illegal, 1);
    repeat (4) step();
    chk("halt_flag", halted, 1);
    chk("halt_req", im_req, 0);
    ack_force = 1'b1;
    repeat (3) step();
    ack_force = 1'b0;
    chk("halt_stays", halted, 1);
    chk("halt_no_req", im_req, 0);
    chk("halt_pc", pc, 3);
    chk("ill_sticky", illegal, 1);
    do_reset();
    chk("ill_cleared", illegal, 0);
    chk("halt_cleared", halted, 0);

    do_reset();
    mem[0] = {7'h02, 8'h07};
    ack_delay = 10;
    run = 1'b1;
    step();
    step();
    chk("rst_mid_req", im_req, 1);
    reset = 1'b1;
    step();
    chk("rst_req_drop", im_req, 0);
    chk("rst_pc", pc, 0);
    reset = 1'b0;
    run = 1'b0;
    ack_force = 1'b1;
    step();
    chk("late_ack_req", im_req, 0);
    chk("late_ack_load", load_a, 0);
    step();
    chk("late_ack_load2", load_a, 0);
    chk("late_ack_pc", pc, 0);
    ack_force = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter PC_W, default 8, program-counter and instruction-memory address width.
REQ-002 Parameter IW, default 15, instruction width: opcode [14:8] (7 b), literal [7:0].
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 run  in  1  level enable; sampled in IDLE and at end of EXEC.
REQ-006 im_req  out  1  instruction-fetch request.
REQ-007 im_addr  out  PC_W  fetch address, equals pc.
REQ-008 im_ack  in  1  fetch acknowledge; im_data valid in the same cycle.
REQ-009 im_data  in  IW  fetched instruction.
REQ-010 load_a / load_b  out  1 each  register write enables.
REQ-011 sel_a  out  2  ALU operand-A source: 0 zero, 1 regA, 2 regB.
REQ-012 sel_b  out  2  ALU operand-B source: 0 zero, 1 regB, 2 literal.
REQ-013 alu_op  out  3  000 ADD, 001 SUB, 110 SHL (operand A << 1); other codes unused.
REQ-014 literal  out  8  ir[7:0].
REQ-015 pc  out  PC_W  current program counter.
REQ-016 halted / illegal  out  1 each  status flags.

Function
REQ-017 FSM states: IDLE, FETCH, EXEC, HALTED.
REQ-018 IDLE: run=1 -> FETCH next cycle; otherwise stay in IDLE.
REQ-019 FETCH: im_req=1, im_addr=pc held stable until im_ack; on im_ack, ir<=im_data, pc<=pc+1 (modulo 2^PC_W, 255->0), -> EXEC.
REQ-020 EXEC lasts exactly one cycle; control outputs decode ir; on exit -> FETCH if run=1, else IDLE.
REQ-021 Minimum throughput: 2 cycles per instruction (ack in first FETCH cycle); each extra wait cycle adds 1.
REQ-022 Decode (EXEC only), as load/sel_a/sel_b/alu_op: 0x00 MOV A,B = load_a/0/1/ADD; 0x01 MOV B,A = load_b/1/0/ADD; 0x02 MOV A,Lit = load_a/0/2/ADD; 0x03 MOV B,Lit = load_b/0/2/ADD; 0x04 ADD A,B = load_a/1/1/ADD; 0x05 ADD B,A = load_b/1/1/ADD; 0x06 ADD A,Lit = load_a/1/2/ADD; 0x07 SUB A,B = load_a/1/1/SUB; 0x08 SHL A,A = load_a/1/0/SHL; 0x09 SHL B,B = load_b/2/0/SHL.
REQ-023 0x0A JMP Lit: no load; pc<=literal in EXEC, overriding the increment.
REQ-024 0x7E NOP: no load; 0x7F HALT: no load, -> HALTED.
REQ-025 Other opcodes: executed as NOP; illegal set sticky until reset.
REQ-026 Outside EXEC: load_a=load_b=0, sel_a=sel_b=0, alu_op=000; im_req=1 only in FETCH.
REQ-027 HALTED: halted=1, im_req=0, no loads; exited only by reset; run is ignored.
REQ-028 run falling during FETCH or EXEC: the in-flight instruction completes, then -> IDLE.
REQ-029 im_ack outside FETCH is ignored.

Reset
REQ-030 reset=1 at an edge: state=IDLE, pc=0, ir=0, halted=0, illegal=0; all outputs at REQ-026 values from the next cycle.
REQ-031 reset has priority over every transition, including mid-FETCH: im_req drops after the reset edge and the pending ack is discarded.

Structure
REQ-032 Shared package holds the opcode constants, alu_op codes, sel_a/sel_b encodings and the state enum.
REQ-033 One sub-module, cs_decoder: combinational mapping from ir opcode to load/sel/alu_op; the FSM and pc stay in control_sequencer.

Verification
REQ-034 Reset, run=1, program [MOV A,42; MOV B,123], ack same cycle -> load_a with sel_b=2, literal=42 at cycle 2; load_b, literal=123 at cycle 4; pc=2.
REQ-035 ADD A,B, then SHL A,A, each with a datapath model -> regA 2+3=5, then 5<<1=10.
REQ-036 im_ack delayed 3 cycles -> im_req/im_addr stable for 4 cycles; pc increments exactly once.
REQ-037 JMP 0x05 at pc=0xFF -> next im_addr=0x05; sequential fetch from 0xFF -> im_addr wraps to 0x00.
REQ-038 Opcode 0x50 -> no loads, illegal=1 persisting until reset; HALT -> halted=1, im_req=0 with run held at 1.
REQ-039 reset asserted during FETCH wait -> next cycle im_req=0, pc=0, state IDLE; a late ack produces no EXEC.
